uart_tx: RTL

Memory-mapped UART transmitter, the transmit counterpart to the SoC's `RXD` input; its serial output replaces the constant `TXD` tie-off. It responds to processor bus accesses gated by an I/O select from the SoC address decoder. Written bytes are buffered in a small FIFO and serialised as 8N1 frames at a fixed baud rate.

---
 rtl/uart_tx_if.sv | 20 ++
 rtl/uart_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Processor bus view of the UART transmitter: I/O select, address, write data,
// byte mask, read strobe and registered read data.
interface uart_tx_if;
  logic        io_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;

  modport master (
    output io_sel, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata
  );

  modport slave (
    input  io_sel, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata
  );
endinterface

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// TXDATA (addr[2]=0) pushes a byte; STATUS (addr[2]=1) reads {overflow, empty, busy, full}.
module uart_tx #(
  parameter int unsigned CLK_FREQ_HZ  = 27000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus,
  output logic      TXD,
  output logic      busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;

  logic bit_end, empty, full, pop, push_req, push, ovf_set, status_rd, txd_d;
  logic unused_bits;

  assign unused_bits = ^{bus.mem_addr[31:3], bus.mem_addr[1:0],
                         bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

  assign bit_end   = (baud_cnt == CNT_MAX);
  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign push_req  = bus.io_sel & bus.mem_wmask[0] & ~bus.mem_addr[2];
  // A full FIFO still takes a byte when the FSM pops in the same cycle.
  assign push      = push_req & (~full | pop);
  assign ovf_set   = push_req & full & ~pop;
  assign status_rd = bus.io_sel & bus.mem_rstrb & bus.mem_addr[2];

  always_comb begin
    busy = ~empty | (state != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (!empty) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: pop request and the value TXD takes after the coming edge
  always_comb begin
    pop   = 1'b0;
    txd_d = 1'b1;
    unique case (state)
      IDLE: begin
        pop   = ~empty;
        txd_d = empty;
      end
      START: txd_d = bit_end ? shift[0] : 1'b0;
      DATA: begin
        if (!bit_end)               txd_d = shift[bit_idx];
        else if (bit_idx == 3'd7)   txd_d = 1'b1;
        else                        txd_d = shift[bit_idx + 3'd1];
      end
      STOP: begin
        pop   = bit_end & ~empty;
        txd_d = ~(bit_end & ~empty);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      TXD      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      TXD <= txd_d;
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      if (pop) begin
        shift   <= fifo_mem[rd_ptr];
        bit_idx <= '0;
      end else if (state == DATA && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new drop in the same cycle as a STATUS read stays flagged.
      overflow <= (overflow & ~status_rd) | ovf_set;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_rdata <= '0;
    end else if (bus.io_sel && bus.mem_rstrb) begin
      bus.mem_rdata <= bus.mem_addr[2] ? {28'b0, overflow, empty, busy, full} : '0;
    end
  end

endmodule
